// File: rtl/lookup3_stream.sv
// -----------------------------------------------------------------------------
// lookup3_stream
// Streaming Jenkins lookup3 "hashlittle" engine. A key arrives as one or more
// 96-bit beats (k0/k1/k2, little-endian bytes). The total length is given on
// in_len with the first beat. Each full 12-byte block is mixed in 3 cycles.
// The final (partial) block is masked to its valid bytes and finalised in
// 2 cycles. The hash is then held on out_hash until the consumer takes it.
//
// Ports:
//   CLK, RST      clock, synchronous active-high reset
//   seed          32-bit seed, present only with LOOKUP3_SEED_PORT_EN defined
//                 (otherwise the INITVAL parameter is the seed)
//   in_valid/in_ready/in_data/in_len   key beat handshake (in_len on 1st beat)
//   out_valid/out_ready/out_hash       result handshake
//   busy          high whenever the engine is not idle
//
// Configuration macro: LOOKUP3_SEED_PORT_EN
// -----------------------------------------------------------------------------
module lookup3_stream #(
    parameter int          LEN_W   = 8,
    parameter logic [31:0] INITVAL = 32'h0
) (
    input  logic             CLK,
    input  logic             RST,
`ifdef LOOKUP3_SEED_PORT_EN
    input  logic [31:0]      seed,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [95:0]      in_data,
    input  logic [LEN_W-1:0] in_len,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_hash,
    output logic             busy
);

    typedef enum logic [2:0] {IDLE, ABSORB, MIX, FINAL, OUT} state_t;

    state_t           state_reg, state_next;
    logic [1:0]       phase_reg;
    logic [LEN_W-1:0] rem_reg;
    logic [31:0]      a_reg, b_reg, c_reg, hash_reg;

    logic [31:0]      seed_w;
`ifdef LOOKUP3_SEED_PORT_EN
    assign seed_w = seed;
`else
    assign seed_w = INITVAL;
`endif

    function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned r);
        return (x << r) | (x >> (32 - r));
    endfunction

    // Length still to be absorbed: on the first beat it comes straight from in_len.
    logic             accept;
    logic [LEN_W-1:0] rem_eff;
    logic             rem_gt12;
    logic [31:0]      init_val;
    logic [95:0]      key_mask, key_m;
    logic [31:0]      abs_a, abs_b, abs_c;

    assign accept   = in_valid && in_ready;
    assign rem_eff  = (state_reg == IDLE) ? in_len : rem_reg;
    assign rem_gt12 = rem_eff > LEN_W'(12);
    assign init_val = 32'hDEADBEEF + 32'(in_len) + seed_w;

    // Byte lane gi is kept only if it lies inside the remaining key length.
    for (genvar gi = 0; gi < 12; gi++) begin : g_mask
        assign key_mask[gi*8 +: 8] = (rem_eff > LEN_W'(gi)) ? 8'hFF : 8'h00;
    end
    assign key_m = in_data & key_mask;

    // The first beat adds onto the freshly initialised a=b=c value.
    assign abs_a = ((state_reg == IDLE) ? init_val : a_reg) + key_m[31:0];
    assign abs_b = ((state_reg == IDLE) ? init_val : b_reg) + key_m[63:32];
    assign abs_c = ((state_reg == IDLE) ? init_val : c_reg) + key_m[95:64];

    // Two mix sub-steps per cycle; sub-step (x,y,r) is x-=y; x^=rot(y,r); y+=z.
    logic [31:0] mix_a, mix_b, mix_c;
    always_comb begin
        mix_a = a_reg;
        mix_b = b_reg;
        mix_c = c_reg;
        case (phase_reg)
            2'd0: begin
                mix_a = (mix_a - mix_c) ^ rotl(mix_c, 4);  mix_c = mix_c + mix_b;
                mix_b = (mix_b - mix_a) ^ rotl(mix_a, 6);  mix_a = mix_a + mix_c;
            end
            2'd1: begin
                mix_c = (mix_c - mix_b) ^ rotl(mix_b, 8);  mix_b = mix_b + mix_a;
                mix_a = (mix_a - mix_c) ^ rotl(mix_c, 16); mix_c = mix_c + mix_b;
            end
            default: begin
                mix_b = (mix_b - mix_a) ^ rotl(mix_a, 19); mix_a = mix_a + mix_c;
                mix_c = (mix_c - mix_b) ^ rotl(mix_b, 4);  mix_b = mix_b + mix_a;
            end
        endcase
    end

    // Final avalanche split over two cycles (rotates 14,11,25,16 then 4,14,24).
    logic [31:0] fin_a, fin_b, fin_c;
    always_comb begin
        fin_a = a_reg;
        fin_b = b_reg;
        fin_c = c_reg;
        if (phase_reg == 2'd0) begin
            fin_c = (fin_c ^ fin_b) - rotl(fin_b, 14);
            fin_a = (fin_a ^ fin_c) - rotl(fin_c, 11);
            fin_b = (fin_b ^ fin_a) - rotl(fin_a, 25);
            fin_c = (fin_c ^ fin_b) - rotl(fin_b, 16);
        end else begin
            fin_a = (fin_a ^ fin_c) - rotl(fin_c, 4);
            fin_b = (fin_b ^ fin_a) - rotl(fin_a, 14);
            fin_c = (fin_c ^ fin_b) - rotl(fin_b, 24);
        end
    end

    // State register
    always_ff @(posedge CLK) begin
        if (RST) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (in_valid) begin
                if (in_len == '0)  state_next = OUT;
                else if (rem_gt12) state_next = MIX;
                else               state_next = FINAL;
            end
            ABSORB: if (in_valid) state_next = rem_gt12 ? MIX : FINAL;
            MIX:    if (phase_reg == 2'd2) state_next = ABSORB;
            FINAL:  if (phase_reg == 2'd1) state_next = OUT;
            OUT:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        in_ready  = (state_reg == IDLE) || (state_reg == ABSORB);
        busy      = (state_reg != IDLE);
        out_valid = (state_reg == OUT);
    end
    assign out_hash = hash_reg;

    // Datapath
    always_ff @(posedge CLK) begin
        if (RST) begin
            a_reg     <= '0;
            b_reg     <= '0;
            c_reg     <= '0;
            rem_reg   <= '0;
            phase_reg <= '0;
            hash_reg  <= 32'hFFFFFFFF;
        end else begin
            case (state_reg)
                IDLE, ABSORB: if (accept) begin
                    a_reg     <= abs_a;
                    b_reg     <= abs_b;
                    c_reg     <= abs_c;
                    rem_reg   <= rem_gt12 ? (rem_eff - LEN_W'(12)) : '0;
                    phase_reg <= '0;
                    // Zero-length key: the initial c value is the hash.
                    if (state_reg == IDLE && in_len == '0) hash_reg <= init_val;
                end
                MIX: begin
                    a_reg     <= mix_a;
                    b_reg     <= mix_b;
                    c_reg     <= mix_c;
                    phase_reg <= phase_reg + 2'd1;
                end
                FINAL: begin
                    a_reg     <= fin_a;
                    b_reg     <= fin_b;
                    c_reg     <= fin_c;
                    phase_reg <= phase_reg + 2'd1;
                    if (phase_reg == 2'd1) hash_reg <= fin_c;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lookup3_stream.sv
// -----------------------------------------------------------------------------
// tb_lookup3_stream
// Three instances (seeds 0, 1, DEADBEEF) share one stimulus stream. A
// transaction-level model predicts in_ready/busy/out_valid per cycle from the
// latency rules. It computes hashes with a software hashlittle over the key
// bytes. One compare process checks every cycle; directed literal checks pin
// the model and the DUT.
// -----------------------------------------------------------------------------
module tb_lookup3_stream;
    localparam int LEN_W = 8;
    localparam int ND    = 3;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             in_valid = 1'b0;
    logic [95:0]      in_data = '0;
    logic [LEN_W-1:0] in_len = '0;
    logic             out_ready = 1'b0;

    logic             in_ready_w  [ND];
    logic             out_valid_w [ND];
    logic             busy_w      [ND];
    logic [31:0]      out_hash_w  [ND];

    always #5 CLK = ~CLK;

    for (genvar gi = 0; gi < ND; gi++) begin : g_dut
        lookup3_stream #(
            .LEN_W  (LEN_W),
            .INITVAL(gi == 0 ? 32'h0 : (gi == 1 ? 32'h1 : 32'hDEADBEEF))
        ) u_dut (
            .CLK      (CLK),
            .RST      (RST),
            .in_valid (in_valid),
            .in_ready (in_ready_w[gi]),
            .in_data  (in_data),
            .in_len   (in_len),
            .out_valid(out_valid_w[gi]),
            .out_ready(out_ready),
            .out_hash (out_hash_w[gi]),
            .busy     (busy_w[gi])
        );
    end

    function automatic logic [31:0] seed_of(input int d);
        return (d == 0) ? 32'h0 : ((d == 1) ? 32'h1 : 32'hDEADBEEF);
    endfunction

    // ---------------- reference hashlittle over key_buf ----------------
    logic [7:0] key_buf [256];
    int         key_len = 0;

    function automatic logic [31:0] rot(input logic [31:0] x, input int k);
        return (x << k) | (x >> (32 - k));
    endfunction

    function automatic logic [31:0] hl(input int len, input logic [31:0] sd);
        logic [31:0] a, b, c;
        logic [31:0] k [3];
        int n, off;
        a = 32'hDEADBEEF + 32'(len) + sd;
        b = a;
        c = a;
        n = len;
        off = 0;
        while (n > 12) begin
            for (int w = 0; w < 3; w++)
                k[w] = {key_buf[off+4*w+3], key_buf[off+4*w+2], key_buf[off+4*w+1], key_buf[off+4*w]};
            a += k[0]; b += k[1]; c += k[2];
            a -= c; a ^= rot(c, 4);  c += b;
            b -= a; b ^= rot(a, 6);  a += c;
            c -= b; c ^= rot(b, 8);  b += a;
            a -= c; a ^= rot(c, 16); c += b;
            b -= a; b ^= rot(a, 19); a += c;
            c -= b; c ^= rot(b, 4);  b += a;
            n -= 12;
            off += 12;
        end
        if (n == 0) return c;
        for (int w = 0; w < 3; w++) k[w] = 32'h0;
        for (int i = 0; i < n; i++) k[i/4] |= 32'(key_buf[off+i]) << (8 * (i % 4));
        a += k[0]; b += k[1]; c += k[2];
        c ^= b; c -= rot(b, 14);
        a ^= c; a -= rot(c, 11);
        b ^= a; b -= rot(a, 25);
        c ^= b; c -= rot(b, 16);
        a ^= c; a -= rot(c, 4);
        b ^= a; b -= rot(a, 14);
        c ^= b; c -= rot(b, 24);
        return c;
    endfunction

    // ---------------- check bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %08h expected %08h", nm, d, act, exp);
        end
    endtask

    // ---------------- transaction-level model ----------------
    bit          m_ready = 1'b1, m_valid = 1'b0, m_busy = 1'b0;
    int          m_cnt = 0, m_beats = 0;
    logic [31:0] m_hash [ND];

    initial forever begin
        @(posedge CLK);
        if (RST) begin
            m_ready = 1'b1; m_valid = 1'b0; m_busy = 1'b0; m_cnt = 0; m_beats = 0;
        end else if (m_valid) begin
            if (out_ready) begin
                m_valid = 1'b0; m_busy = 1'b0; m_ready = 1'b1;
            end
        end else if (m_cnt > 0) begin
            // Non-accepting cycles: 3 mix cycles per block or 2 finalisation cycles.
            m_cnt--;
            if (m_cnt == 0) begin
                if (m_beats == 0) m_valid = 1'b1;
                else              m_ready = 1'b1;
            end
        end else if (m_ready && in_valid) begin
            if (!m_busy) m_beats = (key_len == 0) ? 1 : (key_len + 11) / 12;
            m_beats--;
            m_busy  = 1'b1;
            m_ready = 1'b0;
            if (m_beats == 0) begin
                for (int d = 0; d < ND; d++) m_hash[d] = hl(key_len, seed_of(d));
                if (key_len == 0) m_valid = 1'b1;
                else              m_cnt = 2;
            end else begin
                m_cnt = 3;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    int cyc = 0;
    bit prev_v = 1'b0;
    int rise_q [$];

    initial forever begin
        @(negedge CLK);
        cyc++;
        if (out_valid_w[0] && !prev_v) rise_q.push_back(cyc);
        prev_v = out_valid_w[0];
        if (chk_en) begin
            for (int d = 0; d < ND; d++) begin
                check("in_ready", d, 32'(in_ready_w[d]), 32'(m_ready));
                check("busy", d, 32'(busy_w[d]), 32'(m_busy));
                check("out_valid", d, 32'(out_valid_w[d]), 32'(m_valid));
                if (m_valid) check("out_hash", d, out_hash_w[d], m_hash[d]);
            end
        end
    end

    // ---------------- drivers ----------------
    logic [31:0] got_hash [ND];

    task automatic send_beat(input int b);
        logic [95:0] dat;
        bit acc;
        int n;
        for (int j = 0; j < 12; j++)
            dat[8*j +: 8] = (12*b + j < key_len) ? key_buf[12*b + j] : 8'(8'hA5 ^ j);
        in_data  = dat;
        in_valid = 1'b1;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 60) begin
            @(negedge CLK);
            acc = in_ready_w[0];
            @(posedge CLK);
            #1;
            n++;
        end
        if (!acc) begin
            n_checks++; n_fail++;
            $display("FAIL beat_accept_timeout: beat %0d not accepted in %0d cycles", b, n);
        end
    endtask

    task automatic send_key(input int len, input int gap, input int hold, input bit wait_out);
        int nb, n;
        bit seen;
        key_len = len;
        in_len  = LEN_W'(len);
        nb = (len == 0) ? 1 : (len + 11) / 12;
        for (int b = 0; b < nb; b++) begin
            send_beat(b);
            if (gap > 0 && b < nb - 1) begin
                in_valid = 1'b0;
                repeat (gap) begin @(posedge CLK); #1; end
            end
        end
        in_valid = 1'b0;
        if (wait_out) begin
            seen = 1'b0;
            n = 0;
            while (!seen && n < 60) begin
                @(negedge CLK);
                seen = out_valid_w[0];
                n++;
            end
            if (!seen) begin
                n_checks++; n_fail++;
                $display("FAIL out_valid_timeout: no hash for len %0d", len);
            end
            for (int k = 0; k < hold; k++) @(negedge CLK);
            for (int d = 0; d < ND; d++) got_hash[d] = out_hash_w[d];
            out_ready = 1'b1;
            @(posedge CLK);
            #1;
            out_ready = 1'b0;
        end
    endtask

    task automatic load_pattern(input int len, input int salt);
        for (int i = 0; i < len; i++) key_buf[i] = 8'((i * 7 + salt * 13 + 3) & 255);
    endtask

    task automatic load_text();
        string s;
        s = "Four score and seven years ago";
        for (int i = 0; i < s.len(); i++) key_buf[i] = s[i];
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lens [9];
        lens = '{1, 4, 5, 11, 12, 13, 24, 25, 255};

        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        for (int d = 0; d < ND; d++) begin
            check("reset_out_hash", d, out_hash_w[d], 32'hFFFFFFFF);
            check("reset_in_ready", d, 32'(in_ready_w[d]), 32'h1);
            check("reset_busy", d, 32'(busy_w[d]), 32'h0);
            check("reset_out_valid", d, 32'(out_valid_w[d]), 32'h0);
        end
        chk_en = 1'b1;

        // Pin the reference model to known hashlittle values.
        load_text();
        check("model_text_seed0", 0, hl(30, 32'h0), 32'h17770551);
        check("model_text_seed1", 1, hl(30, 32'h1), 32'hCD628161);
        check("model_len0_seed0", 0, hl(0, 32'h0), 32'hDEADBEEF);
        check("model_len0_seedDB", 2, hl(0, 32'hDEADBEEF), 32'hBD5B7DDE);

        // Zero-length key
        send_key(0, 0, 0, 1'b1);
        check("len0_seed0", 0, got_hash[0], 32'hDEADBEEF);
        check("len0_seedDB", 2, got_hash[2], 32'hBD5B7DDE);

        // 30-byte text, contiguous beats
        load_text();
        send_key(30, 0, 2, 1'b1);
        check("text_seed0", 0, got_hash[0], 32'h17770551);
        check("text_seed1", 1, got_hash[1], 32'hCD628161);

        // Same text with sender gaps and a long consumer stall
        load_text();
        send_key(30, 5, 10, 1'b1);
        check("text_stall_seed0", 0, got_hash[0], 32'h17770551);
        check("text_stall_seed1", 1, got_hash[1], 32'hCD628161);

        // Length sweep across block boundaries (model-checked every cycle)
        foreach (lens[i]) begin
            load_pattern(lens[i], i);
            send_key(lens[i], i % 2, i % 3, 1'b1);
        end

        // Back-to-back 12-byte keys with the consumer always ready
        rise_q.delete();
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            load_pattern(12, 20 + k);
            send_key(12, 0, 0, 1'b0);
        end
        repeat (8) @(posedge CLK);
        #1;
        out_ready = 1'b0;
        check("b2b_hash_count", 0, 32'(rise_q.size()), 32'd4);
        for (int k = 1; k < rise_q.size(); k++)
            check("b2b_period", 0, 32'(rise_q[k] - rise_q[k-1]), 32'd4);

        // Reset in the middle of the second block's mix, then a zero-length key
        load_text();
        key_len = 30;
        in_len  = LEN_W'(30);
        send_beat(0);
        send_beat(1);
        in_valid = 1'b0;
        @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        repeat (6) @(posedge CLK);
        #1;
        send_key(0, 0, 0, 1'b1);
        check("post_rst_len0_seed0", 0, got_hash[0], 32'hDEADBEEF);
        check("post_rst_len0_seed1", 1, got_hash[1], 32'hDEADBEF0);
        check("post_rst_len0_seedDB", 2, got_hash[2], 32'hBD5B7DDE);

        repeat (3) @(posedge CLK);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
